// File: rtl/reg_wire_stream_pipe.sv
// Multi-lane valid/ready register-slice pipeline with a combinational input tap.
// Optional transfer counter (xfer_cnt port) is enabled by defining STREAM_PIPE_CNT_EN.
module reg_wire_stream_pipe #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned STAGES   = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   output logic [CHANNELS-1:0]          out_valid,
   input  logic [CHANNELS-1:0]          out_ready,
   output logic [CHANNELS*DATA_W-1:0]   out_data,
   output logic [CHANNELS*DATA_W-1:0]   tap_data
`ifdef STREAM_PIPE_CNT_EN
   ,
   output logic [CNT_W-1:0]             xfer_cnt
`endif
);

   assign tap_data = in_data;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
         logic [STAGES-1:0] v_q;
         logic [DATA_W-1:0] d_q [STAGES];
         logic [STAGES-1:0] adv;
         logic              accept;

         // A stage may load when the stage after it moves or it is empty itself.
         always_comb begin
            adv = '0;
            adv[STAGES-1] = out_ready[gi] | ~v_q[STAGES-1];
            for (int s = int'(STAGES) - 2; s >= 0; s--) begin
               adv[s] = adv[s+1] | ~v_q[s];
            end
         end

         assign in_ready[gi] = adv[0] & ~flush & ~reset;
         assign accept       = in_valid[gi] & in_ready[gi];

         always_ff @(posedge clk) begin
            if (reset) begin
               v_q <= '0;
               for (int s = 0; s < int'(STAGES); s++) begin
                  d_q[s] <= '0;
               end
            end else if (flush) begin
               v_q <= '0;
            end else begin
               if (adv[0]) begin
                  v_q[0] <= accept;
                  if (accept) begin
                     d_q[0] <= in_data[gi*DATA_W +: DATA_W];
                  end
               end
               // Data only moves with a valid word so idle slices keep their last value.
               for (int s = 1; s < int'(STAGES); s++) begin
                  if (adv[s]) begin
                     v_q[s] <= v_q[s-1];
                     if (v_q[s-1]) begin
                        d_q[s] <= d_q[s-1];
                     end
                  end
               end
            end
         end

         assign out_valid[gi]                  = v_q[STAGES-1];
         assign out_data[gi*DATA_W +: DATA_W]  = d_q[STAGES-1];
      end
   endgenerate

`ifdef STREAM_PIPE_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Transfers during a flush cycle still complete, so they are counted too.
   always_comb begin
      cnt_d = cnt_q;
      for (int k = 0; k < int'(CHANNELS); k++) begin
         cnt_d = cnt_d + CNT_W'(out_valid[k] & out_ready[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule
